// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//   Multi-channel switch debouncer. Each channel synchronises its raw switch
//   input, then runs a small IDLE/ACTIVE FSM with a down-counter driven by a
//   shared count-enable tick.
//     MODE 0 (LOCKOUT): a change is passed to out at once, after which the
//                       input is ignored for STABLE_CNT+1 ticks.
//     MODE 1 (STABLE) : a change is passed to out only after the synchronised
//                       input has differed from out for STABLE_CNT+2 edges
//                       (with tick=1); any bounce back restarts the wait.
//
// Ports
//   clk   : single clock, all logic on posedge
//   rst   : asynchronous active-high reset
//   tick  : count enable shared by all channels (tie 1 for per-cycle counting)
//   sw    : raw asynchronous switch inputs, one bit per channel
//   out   : debounced level per channel
//   rise  : registered one-cycle pulse when out goes 0->1
//   fall  : registered one-cycle pulse when out goes 1->0
//   busy  : channel FSM is in its ACTIVE (lockout / counting) state
// ---------------------------------------------------------------------------
module debounce_bank #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int STABLE_CNT  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [CHANNELS-1:0] sw,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STABLE_CNT);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sw_s;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   out_q, out_d;
        logic                   rise_q, fall_q;

        // Synchroniser chain. The flops carry a reset so a switch held high
        // through reset still appears as a clean 0->1 change afterwards.
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge value of its neighbour; blocking here would collapse
        // the chain into a single stage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= sw[i];
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[s] <= sync_q[s-1];
                end
            end
        end

        assign sw_s = sync_q[SYNC_STAGES-1];

        // State, counter, level and edge-pulse registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= RELOAD;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                // Pulses are derived from the level about to be registered,
                // so they line up with the first cycle of the new out value.
                rise_q  <= out_d & ~out_q;
                fall_q  <= ~out_d & out_q;
            end
        end

        // Next-state logic.
        // NOTE: every output of this block is given its hold value first, so
        // no path leaves a signal unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;

            unique case (state_q)
                IDLE: begin
                    if (sw_s != out_q) begin
                        state_d = ACTIVE;
                        cnt_d   = RELOAD;
                        if (MODE == 0) begin
                            out_d = sw_s;
                        end
                    end
                end

                ACTIVE: begin
                    if (MODE != 0 && sw_s == out_q) begin
                        // Bounce back before the period ended: abandon.
                        state_d = IDLE;
                        cnt_d   = RELOAD;
                    end else if (tick) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            state_d = IDLE;
                            cnt_d   = RELOAD;
                            if (MODE != 0) begin
                                out_d = sw_s;
                            end
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = RELOAD;
                end
            endcase
        end

        assign out[i]  = out_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
        assign busy[i] = (state_q == ACTIVE);
    end

endmodule

// File: tb/tb_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_debounce_bank
//   Drives one LOCKOUT and one STABLE instance of debounce_bank with the same
//   switch/tick stimulus (directed scenarios followed by random traffic) and
//   compares every output, every cycle, against a behavioural model.
// ---------------------------------------------------------------------------
module tb_debounce_bank;

    localparam int CH  = 4;
    localparam int CW  = 16;
    localparam int STB = 3;
    localparam int SS  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [CH-1:0] sw;

    logic [CH-1:0] out0, rise0, fall0, busy0;
    logic [CH-1:0] out1, rise1, fall1, busy1;

    debounce_bank #(
        .CHANNELS(CH), .CNT_W(CW), .STABLE_CNT(STB), .SYNC_STAGES(SS), .MODE(0)
    ) dut_lock (
        .clk(clk), .rst(rst), .tick(tick), .sw(sw),
        .out(out0), .rise(rise0), .fall(fall0), .busy(busy0)
    );

    debounce_bank #(
        .CHANNELS(CH), .CNT_W(CW), .STABLE_CNT(STB), .SYNC_STAGES(SS), .MODE(1)
    ) dut_stable (
        .clk(clk), .rst(rst), .tick(tick), .sw(sw),
        .out(out1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Index 0 = lockout behaviour, 1 = stable-period behaviour.
    logic [CH-1:0] m_out  [2];
    logic [CH-1:0] m_rise [2];
    logic [CH-1:0] m_fall [2];
    logic [CH-1:0] m_busy [2];
    int            m_ticks[2][CH];   // ticked edges seen since going busy
    logic [CH-1:0] delay_q[$];       // pin history; front is what the FSM sees

    task automatic model_reset();
        for (int md = 0; md < 2; md++) begin
            m_out[md]  = '0;
            m_rise[md] = '0;
            m_fall[md] = '0;
            m_busy[md] = '0;
            for (int c = 0; c < CH; c++) m_ticks[md][c] = 0;
        end
        delay_q.delete();
        for (int k = 0; k < SS; k++) delay_q.push_back('0);
    endtask

    task automatic take(input int md, input int c, input logic v);
        m_out[md][c] = v;
        if (v) m_rise[md][c] = 1'b1;
        else   m_fall[md][c] = 1'b1;
    endtask

    task automatic model_edge();
        logic [CH-1:0] s;
        s = delay_q.pop_front();
        delay_q.push_back(sw);
        for (int md = 0; md < 2; md++) begin
            m_rise[md] = '0;
            m_fall[md] = '0;
            for (int c = 0; c < CH; c++) begin
                if (md == 0) begin
                    // Lockout: take any change while free, then stay deaf
                    // for STB+1 ticked edges.
                    if (!m_busy[0][c]) begin
                        if (s[c] != m_out[0][c]) begin
                            take(0, c, s[c]);
                            m_busy[0][c]  = 1'b1;
                            m_ticks[0][c] = 0;
                        end
                    end else if (tick) begin
                        if (m_ticks[0][c] == STB) m_busy[0][c] = 1'b0;
                        else m_ticks[0][c]++;
                    end
                end else begin
                    // Stable: the difference must survive one arming edge plus
                    // STB+1 ticked edges; agreement at any point cancels.
                    if (s[c] == m_out[1][c]) begin
                        m_busy[1][c] = 1'b0;
                    end else if (!m_busy[1][c]) begin
                        m_busy[1][c]  = 1'b1;
                        m_ticks[1][c] = 0;
                    end else if (tick) begin
                        if (m_ticks[1][c] == STB) begin
                            take(1, c, s[c]);
                            m_busy[1][c] = 1'b0;
                        end else begin
                            m_ticks[1][c]++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare();
        check("lock.out",  out0,  m_out[0]);
        check("lock.rise", rise0, m_rise[0]);
        check("lock.fall", fall0, m_fall[0]);
        check("lock.busy", busy0, m_busy[0]);
        check("stab.out",  out1,  m_out[1]);
        check("stab.rise", rise1, m_rise[1]);
        check("stab.fall", fall1, m_fall[1]);
        check("stab.busy", busy1, m_busy[1]);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Assert reset between edges and check the outputs clear without a clock.
    task automatic reset_now();
        rst = 1'b1;
        #1;
        check("arst.lock.out",  out0,  '0);
        check("arst.lock.rise", rise0, '0);
        check("arst.lock.fall", fall0, '0);
        check("arst.lock.busy", busy0, '0);
        check("arst.stab.out",  out1,  '0);
        check("arst.stab.rise", rise1, '0);
        check("arst.stab.fall", fall1, '0);
        check("arst.stab.busy", busy1, '0);
        model_reset();
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        int pflip;
        rst  = 1'b1;
        sw   = '0;
        tick = 1'b1;
        model_reset();
        run(3);
        rst = 1'b0;
        run(4);

        // Clean step on channel 0.
        sw[0] = 1'b1;
        run(10);

        // Bouncing channel 1: toggles while the lockout is running.
        sw[1] = 1'b1; step();
        sw[1] = 1'b0; step();
        sw[1] = 1'b1; step();
        sw[1] = 1'b0;
        run(14);

        // Channel 2: short pulse that must be filtered, then a long one.
        sw[2] = 1'b1; run(4);
        sw[2] = 1'b0; run(6);
        sw[2] = 1'b1; run(12);

        // Channel 3 with a tick only every 4th cycle.
        sw[3] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick = (k % 4 == 0);
            step();
        end
        tick = 1'b1;
        run(4);

        // Reset mid-count with all switches high.
        sw = '0;
        run(16);
        sw = '1;
        run(4);
        reset_now();
        run(16);

        // Opposite edges on channels 0 and 3 at the same time.
        sw = 4'b1000;
        run(16);
        sw = 4'b0001;
        run(16);

        // Random traffic with varying bounce density and tick rate.
        for (int k = 0; k < 900; k++) begin
            case ((k / 150) % 3)
                0:       pflip = 3;
                1:       pflip = 12;
                default: pflip = 25;
            endcase
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, pflip - 1) == 0) sw[c] = ~sw[c];
            end
            tick = ((k / 300) == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if ($urandom_range(0, 249) == 0) reset_now();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Parametrised multi-channel switch debouncer. It is the successor to the single-channel lockout debouncer. It adds:
- a per-channel input synchroniser
- a configurable count width and period
- a selectable lockout or stable-period mode
- a shared prescale tick
- registered rise/fall pulses

It sits between raw board switches/buttons and control FSMs. One instance serves a whole switch bank.

Parameters:
CHANNELS, 4, number of independent switch channels (>=1)
CNT_W, 16, width of each channel's period counter
STABLE_CNT, 3, period reload value; must be < 2**CNT_W; 0 legal
SYNC_STAGES, 2, synchroniser flops per channel (>=1)
MODE, 0, 0 = LOCKOUT (pass edge immediately, then ignore input); 1 = STABLE (pass edge only after input held)

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
tick  input  1  count enable for all channels; tie 1 for per-cycle counting
sw  input  CHANNELS  raw asynchronous switch inputs
out  output  CHANNELS  debounced level per channel
rise  output  CHANNELS  one-cycle pulse on out 0->1
fall  output  CHANNELS  one-cycle pulse on out 1->0
busy  output  CHANNELS  channel is in HOLD/COUNT state

Behaviour:
- Reset (async, rst=1): all sync flops, out, rise and fall go to 0. Every channel goes to IDLE with cnt=STABLE_CNT. busy=0.
- Synchroniser: sw_s[i] is sw[i] delayed through SYNC_STAGES flops. All decisions use sw_s only.
- Channels are fully independent. There is no cross-channel interaction except the shared tick.
- Per-channel FSM, states IDLE and ACTIVE. busy = (state==ACTIVE).
- MODE 0 (LOCKOUT):
  - IDLE, sw_s!=out: at that edge out<=sw_s, pulse rise/fall, go to ACTIVE, cnt<=STABLE_CNT.
  - ACTIVE: sw_s is ignored.
    - tick=1 and cnt!=0: cnt<=cnt-1.
    - tick=1 and cnt==0: go to IDLE, cnt<=STABLE_CNT.
    - tick=0: hold.
  - With tick=1 the lockout lasts STABLE_CNT+1 cycles.
  - A mismatch remaining on return to IDLE is taken on the next edge.
- MODE 1 (STABLE):
  - IDLE, sw_s!=out: go to ACTIVE, cnt<=STABLE_CNT. out is unchanged.
  - ACTIVE, sw_s==out (bounce back): go to IDLE, cnt<=STABLE_CNT. No output change. Takes priority over tick.
  - ACTIVE, sw_s!=out:
    - tick=1 and cnt!=0: cnt-1.
    - tick=1 and cnt==0: out<=sw_s, pulse rise/fall, go to IDLE, cnt<=STABLE_CNT.
    - tick=0: hold.
  - With tick=1, out changes on the (STABLE_CNT+2)th consecutive edge sampling sw_s!=out.
- Latency from the sw pin (tick=1):
  - MODE 0: SYNC_STAGES+1 edges.
  - MODE 1: SYNC_STAGES+STABLE_CNT+2 edges.
- rise/fall are registered. They are asserted for exactly the one cycle following the edge that updates out. They are never both high, and are 0 in all other cycles.
- Counter: unsigned CNT_W bits. It never decrements below 0 and never wraps.
- sw held at 1 through reset: after release this is treated as a normal 0->1 change, so rise pulses once.
- rst asserted mid-count: immediate return to reset values. No pulse is emitted.

Test Plan:
Common setup: CHANNELS=4, STABLE_CNT=3, SYNC_STAGES=2, tick=1.
- MODE 0, clean 0->1 step on sw[0] -> out[0]=1 and rise[0]=1 for one cycle, 3 edges after the step. busy[0]=1 for 4 cycles. Other channels stay 0.
- MODE 0, sw[1] toggles 1,0,1,0 each cycle after the first change (timed within the 4-cycle lockout after out changes) -> out[1] rises once, then falls once after busy drops. Exactly one rise and one fall.
- MODE 1, sw[2] high for 4 cycles then low -> out[2] never changes, no pulses. Then high for 8 cycles -> out[2]=1 on the 5th edge of sw_s high (7 edges after the pin), with a single rise.
- MODE 1, tick pulsed every 4th cycle, sw[3] held high -> rise[3] arrives 4x later than with tick=1. Counter holds while tick=0.
- Any mode, rst=1 asserted mid-ACTIVE with cnt=2 -> out, rise, fall and busy are 0 asynchronously. After release with sw held high, exactly one rise per channel.
- Simultaneous opposite edges on sw[0] (rise) and sw[3] (fall) -> rise[0] and fall[3] are both asserted in the same cycle, with independent timing.
